arcade_input_ctrl: RTL
======================

# arcade_input_ctrl

Player-input controller between `user_io` (PS/2 key strobes, two joystick words) and the game core's button inputs. It holds keyboard button state and merges it with both joysticks. It applies the cabinet-rotation control mapping. It sequences coin insertions as frame-timed pulses with a small credit queue, so rapid or overlapping coin presses are never lost or merged.

## Interface
Parameters:
- `PULSE_FRAMES`, 4: frame ticks `btn_coin` stays high per coin
- `GAP_FRAMES`, 4: frame ticks of forced low between coin pulses
- `COIN_QDEPTH`, 3: maximum queued coins (saturating)
- `AUTOFIRE_DIV`, 4: frame ticks per autofire half-period

Ports:
- `clk_sys`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `key_strobe`  in  1  one-cycle key event valid
- `key_pressed`  in  1  1 = make, 0 = break
- `key_code`  in  8  PS/2 set-2 scancode
- `joystick_0`, `joystick_1`  in  8 each  [0]right [1]left [2]down [3]up [4]fire [5]barrier [6]coin [7]start
- `rotate`  in  1  0 = rotated mapping, 1 = normal
- `vblank`  in  1  core vertical blank; rising edge = frame tick
- `autofire_on`  in  1  autofire request (ignored unless `AUTOFIRE_EN`)
- `btn_left`, `btn_right`, `btn_fire`, `btn_barrier`  out  1 each
- `btn_coin`  out  1  sequenced coin pulse
- `btn_player_start`  out  2  [0] one player, [1] two players
- `coin_pending`  out  2  queued coin count

## Operation
- Key latches on `key_strobe`, set to `key_pressed`: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x76 coin, 0x05 start1, 0x06 start2, 0x29 fire, 0x11 barrier. Other codes are ignored.
- Merged directions are keyboard OR `joystick_0` OR `joystick_1`.
  - `rotate`=0: left ← down, right ← up.
  - `rotate`=1: left ← left, right ← right.
- Fire and barrier are ORed from all sources.
- `btn_player_start[0]` = key start1 OR `joystick_0[7]`.
- `btn_player_start[1]` = key start2 OR `joystick_1[7]`.
- Coin request is the rising edge of the merged coin level (key coin OR `joystick_0[6]` OR `joystick_1[6]`). Each request increments the queue, saturating at `COIN_QDEPTH`; excess requests are dropped.
- Coin FSM:
  - IDLE: if queue>0, go to PULSE and decrement the queue.
  - PULSE: `btn_coin`=1; after `PULSE_FRAMES` ticks go to GAP.
  - GAP: `btn_coin`=0; after `GAP_FRAMES` ticks go to IDLE.
- Simultaneous request and dequeue leaves the queue unchanged. A request at saturation with a simultaneous dequeue leaves the queue at `COIN_QDEPTH`.
- Frame counter clears on every state entry.
- Frame tick = `vblank` high now and low last cycle, using a registered previous value.

## Timing
- Reset values: all outputs 0, FSM IDLE, queue 0, key latches 0, frame counter 0, previous vblank 0.
- Button outputs are registered, with 1-cycle latency from `key_strobe` or a joystick change.
- Coin request to `btn_coin` rising edge is 2 cycles when idle: 1 cycle edge detect, 1 cycle FSM.
- `btn_coin` high time is exactly `PULSE_FRAMES` frame ticks, counted from the first tick after entering PULSE.
- `coin_pending` reflects the queue register, with 1-cycle latency.
- Reset mid-pulse drops `btn_coin` immediately and clears the queue. Keys held through reset need a new make strobe.
- `rotate` changes take effect on the next cycle; there is no glitch filtering.

## Configuration
- `ARCADE_INPUT_AUTOFIRE_EN` defined:
  - While `autofire_on`=1 and merged fire is held, `btn_fire` goes 1 immediately, then toggles every `AUTOFIRE_DIV` frame ticks.
  - Releasing fire forces 0 and resets the phase.
  - `autofire_on`=0 gives plain held fire.
- `ARCADE_INPUT_AUTOFIRE_EN` undefined: `btn_fire` is the merged level, `autofire_on` is unused, and no autofire counter is built.

## Structure
- Package `arcade_input_pkg`:
  - scancode localparams
  - joystick bit-index localparams
  - coin FSM enum `coin_state_t` {IDLE, PULSE, GAP}
- Sub-module `coin_sequencer`: edge detect, saturating queue, FSM, frame counter, parameterized by `PULSE_FRAMES`, `GAP_FRAMES`, `COIN_QDEPTH`.
- The top level holds the key latches, mapping and autofire.

## Test plan
- Strobe 0x6B make, `rotate`=1 → `btn_left`=1 next cycle; 0x6B break → 0. With `rotate`=0, 0x72 make → `btn_left`=1.
- One ESC make/break, PULSE_FRAMES=4 → `btn_coin` high 2 cycles later, low after exactly 4 vblank rising edges, then 4 ticks of gap.
- Five `joystick_0[6]` edges within one frame → `coin_pending` peaks at 3 (with one pulse active), exactly 4 coin pulses total, each separated by GAP.
- Assert `reset` mid-PULSE with queue=2 → `btn_coin`, `coin_pending` and `btn_*` all 0 asynchronously; no pulse after release.
- Request arriving in the same cycle as the IDLE→PULSE dequeue, queue=1 → queue stays 1 and 2 pulses total.
- With `ARCADE_INPUT_AUTOFIRE_EN`, DIV=4, fire held and `autofire_on`=1 → `btn_fire` pattern 1,0,1 toggling every 4 ticks; release → 0 the next cycle.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared scancodes, joystick bit positions and types for the arcade input controller.
package arcade_input_pkg;

   localparam logic [7:0] SC_UP      = 8'h75;
   localparam logic [7:0] SC_DOWN    = 8'h72;
   localparam logic [7:0] SC_LEFT    = 8'h6B;
   localparam logic [7:0] SC_RIGHT   = 8'h74;
   localparam logic [7:0] SC_COIN    = 8'h76;
   localparam logic [7:0] SC_START1  = 8'h05;
   localparam logic [7:0] SC_START2  = 8'h06;
   localparam logic [7:0] SC_FIRE    = 8'h29;
   localparam logic [7:0] SC_BARRIER = 8'h11;

   localparam int JOY_RIGHT   = 0;
   localparam int JOY_LEFT    = 1;
   localparam int JOY_DOWN    = 2;
   localparam int JOY_UP      = 3;
   localparam int JOY_FIRE    = 4;
   localparam int JOY_BARRIER = 5;
   localparam int JOY_COIN    = 6;
   localparam int JOY_START   = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_state_t;

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
      logic coin;
      logic start1;
      logic start2;
      logic fire;
      logic barrier;
   } key_state_t;

   // Unmapped scancodes leave the key state untouched.
   function automatic key_state_t key_apply(key_state_t k, logic [7:0] code, logic pressed);
      key_state_t r;
      r = k;
      case (code)
         SC_UP:      r.up      = pressed;
         SC_DOWN:    r.down    = pressed;
         SC_LEFT:    r.left    = pressed;
         SC_RIGHT:   r.right   = pressed;
         SC_COIN:    r.coin    = pressed;
         SC_START1:  r.start1  = pressed;
         SC_START2:  r.start2  = pressed;
         SC_FIRE:    r.fire    = pressed;
         SC_BARRIER: r.barrier = pressed;
         default:    r         = k;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/arcade_input_ctrl_if.sv
// Key-event, joystick and game-button bundle between user_io and the controller.
interface arcade_input_ctrl_if;
   logic       key_strobe;
   logic       key_pressed;
   logic [7:0] key_code;
   logic [7:0] joystick_0;
   logic [7:0] joystick_1;
   logic       btn_left;
   logic       btn_right;
   logic       btn_fire;
   logic       btn_barrier;
   logic       btn_coin;
   logic [1:0] btn_player_start;
   logic [1:0] coin_pending;

   modport master (
      output key_strobe, key_pressed, key_code, joystick_0, joystick_1,
      input  btn_left, btn_right, btn_fire, btn_barrier, btn_coin,
             btn_player_start, coin_pending
   );

   modport slave (
      input  key_strobe, key_pressed, key_code, joystick_0, joystick_1,
      output btn_left, btn_right, btn_fire, btn_barrier, btn_coin,
             btn_player_start, coin_pending
   );
endinterface

// File: rtl/arcade_input_ctrl_coin_sequencer.sv
// Coin sequencer: coin-level edge detect, saturating credit queue and frame-timed pulse FSM.
// state | meaning
// IDLE  | waiting for a queued credit
// PULSE | btn_coin high for PULSE_FRAMES frame ticks
// GAP   | btn_coin forced low for GAP_FRAMES frame ticks
module coin_sequencer
   import arcade_input_pkg::*;
#(
   parameter int PULSE_FRAMES = 4,
   parameter int GAP_FRAMES   = 4,
   parameter int COIN_QDEPTH  = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       coin_level,
   input  logic       frame_tick,
   output logic       btn_coin,
   output logic [1:0] coin_pending
);

   localparam int MAXF = (PULSE_FRAMES > GAP_FRAMES) ? PULSE_FRAMES : GAP_FRAMES;
   localparam int CW   = $clog2(MAXF + 1);
   localparam logic [1:0] QMAX = 2'(COIN_QDEPTH);

   coin_state_t   state, state_n;
   logic [CW-1:0] frame_cnt, frame_cnt_n;
   logic [1:0]    queue, queue_n;
   logic          coin_prev;
   logic          req, deq;

   assign req = coin_level & ~coin_prev;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         frame_cnt <= '0;
         queue     <= '0;
         coin_prev <= 1'b0;
      end else begin
         state     <= state_n;
         frame_cnt <= frame_cnt_n;
         queue     <= queue_n;
         coin_prev <= coin_level;
      end
   end

   always_comb begin
      state_n     = state;
      frame_cnt_n = frame_cnt;
      deq         = 1'b0;
      case (state)
         IDLE: begin
            frame_cnt_n = '0;
            if (queue != 2'd0) begin
               state_n = PULSE;
               deq     = 1'b1;
            end
         end
         PULSE: if (frame_tick) begin
            if (frame_cnt == CW'(PULSE_FRAMES - 1)) begin
               state_n     = GAP;
               frame_cnt_n = '0;
            end else begin
               frame_cnt_n = frame_cnt + 1'b1;
            end
         end
         GAP: if (frame_tick) begin
            if (frame_cnt == CW'(GAP_FRAMES - 1)) begin
               state_n     = IDLE;
               frame_cnt_n = '0;
            end else begin
               frame_cnt_n = frame_cnt + 1'b1;
            end
         end
         default: begin
            state_n     = IDLE;
            frame_cnt_n = '0;
         end
      endcase

      // A request coinciding with a dequeue replaces the departing credit.
      queue_n = queue;
      if (req && !deq) begin
         if (queue != QMAX) queue_n = queue + 2'd1;
      end else if (!req && deq) begin
         queue_n = queue - 2'd1;
      end
   end

   assign btn_coin     = (state == PULSE);
   assign coin_pending = queue;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input controller: key latches, joystick merge, rotation mapping and coin sequencing.
// Optional autofire on btn_fire is built only when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_ctrl
   import arcade_input_pkg::*;
#(
   parameter int PULSE_FRAMES = 4,
   parameter int GAP_FRAMES   = 4,
   parameter int COIN_QDEPTH  = 3,
   parameter int AUTOFIRE_DIV = 4
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic rotate,
   input  logic vblank,
   input  logic autofire_on,
   arcade_input_ctrl_if.slave io
);

   key_state_t keys, keys_n;
   logic       vblank_prev, frame_tick;
   logic       up_n, down_n, left_n, right_n, fire_n, barrier_n, coin_n;
   logic       fire_out_n;
   logic       left_q, right_q, fire_q, barrier_q;
   logic [1:0] start_q;
   logic       btn_coin_w;
   logic [1:0] coin_pending_w;

   // Outputs are registered from the post-strobe key state for single-cycle latency.
   always_comb begin
      keys_n = io.key_strobe ? key_apply(keys, io.key_code, io.key_pressed) : keys;
   end

   assign frame_tick = vblank & ~vblank_prev;
   assign up_n      = keys_n.up      | io.joystick_0[JOY_UP]      | io.joystick_1[JOY_UP];
   assign down_n    = keys_n.down    | io.joystick_0[JOY_DOWN]    | io.joystick_1[JOY_DOWN];
   assign left_n    = keys_n.left    | io.joystick_0[JOY_LEFT]    | io.joystick_1[JOY_LEFT];
   assign right_n   = keys_n.right   | io.joystick_0[JOY_RIGHT]   | io.joystick_1[JOY_RIGHT];
   assign fire_n    = keys_n.fire    | io.joystick_0[JOY_FIRE]    | io.joystick_1[JOY_FIRE];
   assign barrier_n = keys_n.barrier | io.joystick_0[JOY_BARRIER] | io.joystick_1[JOY_BARRIER];
   assign coin_n    = keys_n.coin    | io.joystick_0[JOY_COIN]    | io.joystick_1[JOY_COIN];

`ifdef ARCADE_INPUT_AUTOFIRE_EN
   localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
   logic [AW-1:0] af_cnt, af_cnt_n;
   logic          af_low, af_low_n;

   always_comb begin
      af_cnt_n = af_cnt;
      af_low_n = af_low;
      if (!(fire_n && autofire_on)) begin
         af_cnt_n = '0;
         af_low_n = 1'b0;
      end else if (frame_tick) begin
         if (af_cnt == AW'(AUTOFIRE_DIV - 1)) begin
            af_cnt_n = '0;
            af_low_n = ~af_low;
         end else begin
            af_cnt_n = af_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         af_cnt <= '0;
         af_low <= 1'b0;
      end else begin
         af_cnt <= af_cnt_n;
         af_low <= af_low_n;
      end
   end

   assign fire_out_n = fire_n & ~af_low_n;
`else
   localparam int unused_autofire_div = AUTOFIRE_DIV;
   logic unused_autofire_on;
   assign unused_autofire_on = autofire_on;
   assign fire_out_n         = fire_n;
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         keys        <= '0;
         vblank_prev <= 1'b0;
         left_q      <= 1'b0;
         right_q     <= 1'b0;
         fire_q      <= 1'b0;
         barrier_q   <= 1'b0;
         start_q     <= 2'b00;
      end else begin
         keys        <= keys_n;
         vblank_prev <= vblank;
         left_q      <= rotate ? left_n  : down_n;
         right_q     <= rotate ? right_n : up_n;
         fire_q      <= fire_out_n;
         barrier_q   <= barrier_n;
         start_q     <= {keys_n.start2 | io.joystick_1[JOY_START],
                         keys_n.start1 | io.joystick_0[JOY_START]};
      end
   end

   coin_sequencer #(
      .PULSE_FRAMES (PULSE_FRAMES),
      .GAP_FRAMES   (GAP_FRAMES),
      .COIN_QDEPTH  (COIN_QDEPTH)
   ) u_coin (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .coin_level   (coin_n),
      .frame_tick   (frame_tick),
      .btn_coin     (btn_coin_w),
      .coin_pending (coin_pending_w)
   );

   assign io.btn_left         = left_q;
   assign io.btn_right        = right_q;
   assign io.btn_fire         = fire_q;
   assign io.btn_barrier      = barrier_q;
   assign io.btn_player_start = start_q;
   assign io.btn_coin         = btn_coin_w;
   assign io.coin_pending     = coin_pending_w;

endmodule
